// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_pkg
// Description : Shared AXI4 response/burst encodings and decerr FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_decerr_rd_engine.sv
`default_nettype none
// ============================================================================
// Module      : axi4_decerr_rd_engine
// Description : Read half of the decode-error slave: streams arlen+1 DECERR beats.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_decerr_rd_engine
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    rd_state_t             r_state, w_next;
    logic [7:0]            r_cnt, w_cnt_next;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            R_IDLE: begin
                if (arvalid && r_arready) begin
                    w_next     = R_DATA;
                    w_cnt_next = arlen;
                end
            end
            R_DATA: begin
                if (r_rvalid && rready) begin
                    if (r_cnt == 8'd0) begin
                        w_next = R_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
            end
            default: w_next = R_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= 8'd0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_arready <= (w_next == R_IDLE);
            r_rvalid  <= (w_next == R_DATA);
            r_rlast   <= (w_next == R_DATA) && (w_cnt_next == 8'd0);
            r_rresp   <= (w_next == R_DATA) ? RESP_DECERR : RESP_OKAY;
            r_rdata   <= '0;
            if (r_state == R_IDLE && arvalid && r_arready) begin
                r_rid <= arid;
            end
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4_decerr_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_decerr_slave
// Description : Default AXI4 slave completing unmapped accesses with DECERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_decerr_slave
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    // Payload fields that carry no meaning for a decode-error response.
    logic w_unused_ok;
    assign w_unused_ok = ^{awaddr, awlen, awsize, awburst, wdata, wstrb,
                           araddr, arsize, arburst};

    wr_state_t           r_wr_state, w_wr_next;
    logic                r_awready, r_wready, r_bvalid;
    logic [ID_WIDTH-1:0] r_bid;
    logic [1:0]          r_bresp;

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (awvalid && r_awready)        w_wr_next = W_DATA;
            W_DATA:  if (wvalid && r_wready && wlast) w_wr_next = W_RESP;
            W_RESP:  if (r_bvalid && bready)          w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == W_IDLE);
            r_wready   <= (w_wr_next == W_DATA);
            r_bvalid   <= (w_wr_next == W_RESP);
            r_bresp    <= (w_wr_next == W_RESP) ? RESP_DECERR : RESP_OKAY;
            if (r_wr_state == W_IDLE && awvalid && r_awready) begin
                r_bid <= awid;
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;

    axi4_decerr_rd_engine #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_engine (
        .clk     (clk),
        .rst     (rst),
        .arid    (arid),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi4_decerr_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_decerr_slave
// Description : Directed vector bench for the AXI4 decode-error slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_decerr_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4_decerr_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    typedef struct {
        logic [3:0] id;
        logic [7:0] len;
        int         beats;
        bit         toggle;
    } rd_vec_t;

    typedef struct {
        logic [3:0] id;
        int         beats;
        logic [3:0] exp_bid;
    } wr_vec_t;

    rd_vec_t rv[4];
    wr_vec_t wv[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input int beats,
                            input logic [3:0] exp_bid, input bit early);
        bit hs;
        if (early) begin
            wvalid = 1'b1;
            wlast  = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                check("w_early_wready", {63'd0, wready}, 64'd0);
            end
        end
        awid    = id;
        awaddr  = 32'h0000_8000;
        awvalid = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            hs = awready;
            tick();
        end
        check("aw_handshake", {63'd0, hs}, 64'd1);
        awvalid = 1'b0;
        check("aw_after", {62'd0, awready, wready}, 64'b01);
        for (int b = 0; b < beats; b++) begin
            wvalid = 1'b1;
            wlast  = (b == beats - 1);
            wdata  = 32'hDEAD_0000 + b;
            hs = 1'b0;
            for (int c = 0; c < 20 && !hs; c++) begin
                hs = wready;
                tick();
            end
            check("w_handshake", {63'd0, hs}, 64'd1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("b_resp", {57'd0, wready, bvalid, bid, bresp}, {57'd0, 1'b0, 1'b1, exp_bid, 2'b11});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done", {62'd0, bvalid, awready}, 64'b01);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [7:0] len,
                           input int beats, input bit toggle);
        bit hs;
        int got;
        logic rr;
        arid    = id;
        arlen   = len;
        araddr  = 32'h0001_0000;
        arvalid = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            hs = arready;
            tick();
        end
        check("ar_handshake", {63'd0, hs}, 64'd1);
        arvalid = 1'b0;
        check("ar_after", {62'd0, arready, rvalid}, 64'b01);
        got = 0;
        rr  = 1'b1;
        for (int c = 0; c < 700 && got < beats; c++) begin
            rready = rr;
            if (!rvalid) begin
                check("r_valid_drop", {63'd0, rvalid}, 64'd1);
                got = beats;
            end else begin
                check("r_beat", {25'd0, rid, rdata, rresp, rlast},
                      {25'd0, id, 32'd0, 2'b11, (got == beats - 1)});
                if (rr) got++;
            end
            tick();
            rr = toggle ? ~rr : 1'b1;
        end
        rready = 1'b0;
        check("r_count", got, beats);
        check("r_done", {61'd0, rvalid, rlast, arready}, 64'b001);
    endtask

    initial begin
        rv[0] = '{id: 4'hA, len: 8'd3, beats: 4,  toggle: 1'b0};
        rv[1] = '{id: 4'h3, len: 8'd7, beats: 8,  toggle: 1'b1};
        rv[2] = '{id: 4'h0, len: 8'd0, beats: 1,  toggle: 1'b0};
        rv[3] = '{id: 4'hF, len: 8'd1, beats: 2,  toggle: 1'b1};
        wv[0] = '{id: 4'h5, beats: 1, exp_bid: 4'h5};
        wv[1] = '{id: 4'hC, beats: 4, exp_bid: 4'hC};
        wv[2] = '{id: 4'h1, beats: 2, exp_bid: 4'h1};

        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b10; arvalid = 1'b0;
        rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid},
              16'd0);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_reset", {61'd0, awready, arready, wready}, 64'b110);

        for (int i = 0; i < 3; i++) do_write(wv[i].id, wv[i].beats, wv[i].exp_bid, 1'b0);
        for (int i = 0; i < 4; i++) do_read(rv[i].id, rv[i].len, rv[i].beats, rv[i].toggle);

        // Concurrent AW and AR in the same cycle, with the longest read burst.
        fork
            do_write(4'h7, 3, 4'h7, 1'b0);
            do_read(4'h6, 8'hFF, 256, 1'b0);
        join

        do_write(4'h9, 1, 4'h9, 1'b1);

        // Reset while beat 2 of a six-beat burst is on the bus.
        arid = 4'h9; arlen = 8'd5; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        check("mid_beat1", {62'd0, rvalid, arready}, 64'b10);
        tick();
        check("mid_beat2", {62'd0, rvalid, rlast}, 64'b10);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {61'd0, rvalid, arready, awready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rready = 1'b0;
        check("rst_release", {62'd0, arready, rvalid}, 64'd0);
        tick();
        check("rst_first_edge", {62'd0, arready, rvalid}, 64'b10);
        do_read(4'h2, 8'd2, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
